// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the RV32I pipeline stall/flush control path.
// The control bundle struct is also consumed by the pipeline stage registers.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE = '0;

    // Bubbles into every flushable register while reset is held.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_stall:     1'b0,
        pc_redirect:  1'b0,
        if_id_stall:  1'b0,
        if_id_flush:  1'b1,
        id_ex_stall:  1'b0,
        id_ex_flush:  1'b1,
        ex_mem_stall: 1'b0,
        mem_wb_flush: 1'b1
    };

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the ID instruction.
// Writes to x0 are discarded by the register file, so they never create a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush arbiter for the 5-stage pipeline: dmem wait, redirect,
// load-use and fetch wait in that priority, plus wrong-path fetch tracking.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ack,
    input  logic              dmem_req,
    input  logic              dmem_ack,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              pc_redirect,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_stall,
    output logic              id_ex_flush,
    output logic              ex_mem_stall,
    output logic              mem_wb_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              err_timeout
);

    localparam int WW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WW-1:0]    WAIT_MAX  = WW'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    ctrl_state_t      state_reg, state_next;
    logic [WW-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic             err_reg, err_next;
    pipe_ctrl_t       ctrl;
    logic             dmem_wait;
    logic             load_use;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign dmem_wait = dmem_req && !dmem_ack;

    always_comb begin
        ctrl       = CTRL_NONE;
        state_next = state_reg;
        if (!reset) begin
            ctrl = CTRL_RESET;
        end else if (dmem_wait) begin
            // Freeze everything up to MEM; a branch in EX simply waits its turn.
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (state_reg == DISCARD) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.pc_redirect = 1'b1;
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            if (!imem_ack) begin
                state_next = DISCARD;
            end
        end else if (load_use || !imem_ack) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end
        // The wrong-path fetch retires on its ack even while MEM freezes the
        // pipe; IF/ID is held then, so the instruction is never captured.
        if (reset && (state_reg == DISCARD) && imem_ack) begin
            state_next = RUN;
        end
    end

    always_comb begin
        wait_cnt_next  = '0;
        err_next       = err_reg;
        stall_cnt_next = stall_cnt_reg;
        if (dmem_wait) begin
            wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
            if (wait_cnt_next == WAIT_MAX) begin
                err_next = 1'b1;
            end
        end
        if (ctrl.pc_stall && (stall_cnt_reg != STALL_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            err_reg       <= err_next;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign pc_redirect  = ctrl.pc_redirect;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_stall = ctrl.ex_mem_stall;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign stall_cnt    = stall_cnt_reg;
    assign err_timeout  = err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a per-cycle priority model.
module tb_pipeline_hazard_ctrl;

    localparam int WT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ack, dmem_req, dmem_ack;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic        pc_stall, pc_redirect, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [31:0] stall_cnt;
    logic        err_timeout;
    logic [7:0]  dut_ctrl;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    bit          m_discard;
    int          m_wait;
    logic [31:0] m_cnt;
    bit          m_err;

    pipeline_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .imem_ack(imem_ack), .dmem_req(dmem_req),
        .dmem_ack(dmem_ack), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_flush(mem_wb_flush),
        .stall_cnt(stall_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {pc_stall, pc_redirect, if_id_stall, if_id_flush,
                       id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        imem_ack = 1'b1; dmem_req = 1'b0; dmem_ack = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step(input string tag);
        bit         p1, lu;
        logic [7:0] e;
        #2;
        p1 = dmem_req && !dmem_ack;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (p1)                    e = 8'b1010_1011;
        else if (m_discard)        e = 8'b1001_0000;
        else if (ex_branch_taken)  e = 8'b0101_0100;
        else if (lu || !imem_ack)  e = 8'b1010_0100;
        else                       e = 8'b0000_0000;
        check_eq({tag, "_ctrl"}, {24'd0, dut_ctrl}, {24'd0, e});
        check_eq({tag, "_cnt"}, stall_cnt, m_cnt);
        check_eq({tag, "_err"}, {31'd0, err_timeout}, {31'd0, m_err});
        $display("[TB] %s ctrl=%b cnt=%0d err=%0b", tag, dut_ctrl, stall_cnt, err_timeout);
        @(posedge clk);
        if (p1) begin
            if (m_wait < WT) m_wait++;
            if (m_wait == WT) m_err = 1'b1;
        end else begin
            m_wait = 0;
        end
        if (e[7] && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_discard) begin
            if (imem_ack) m_discard = 1'b0;
        end else if (!p1 && ex_branch_taken && !imem_ack) begin
            m_discard = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_eq({tag, "_rst_ctrl"}, {24'd0, dut_ctrl}, 32'h15);
        check_eq({tag, "_rst_cnt"}, stall_cnt, 32'd0);
        check_eq({tag, "_rst_err"}, {31'd0, err_timeout}, 32'd0);
        m_discard = 1'b0; m_wait = 0; m_cnt = '0; m_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #2;
        do_reset("init");

        // 1: load-use on rs1, one bubble; then rd = x0 gives none
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        step("t1_lu");
        idle(); step("t1_adv");
        check_eq("t1_stall_cnt", stall_cnt, 32'd1);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        step("t1_x0");
        check_eq("t1_x0_cnt", stall_cnt, 32'd1);

        // 2: three fetch-wait cycles
        do_reset("t2");
        for (int i = 0; i < 3; i++) begin
            idle(); imem_ack = 1'b0; step("t2_fw");
        end
        idle(); step("t2_adv");
        check_eq("t2_stall_cnt", stall_cnt, 32'd3);

        // 3: redirect while fetch pending, ack after two cycles
        do_reset("t3");
        idle(); ex_branch_taken = 1'b1; imem_ack = 1'b0; step("t3_br");
        idle(); imem_ack = 1'b0; step("t3_dis");
        idle(); imem_ack = 1'b0; step("t3_dis");
        idle(); step("t3_drop");
        idle(); step("t3_run");

        // 4: dmem wait overrides branch and load-use; ack cycle redirects
        do_reset("t4");
        for (int i = 0; i < 5; i++) begin
            idle();
            dmem_req = 1'b1; dmem_ack = (i == 4);
            ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
            id_rs2 = 5'd7; id_use_rs2 = 1'b1;
            step(i == 4 ? "t4_ack" : "t4_wait");
        end
        idle(); step("t4_adv");

        // 5: timeout after WT wait cycles, sticky past ack
        do_reset("t5");
        for (int i = 0; i < 10; i++) begin
            idle(); dmem_req = 1'b1; step("t5_wait");
            if (i == WT - 2) check_eq("t5_not_yet", {31'd0, err_timeout}, 32'd0);
            if (i == WT - 1) check_eq("t5_set", {31'd0, err_timeout}, 32'd1);
        end
        idle(); dmem_req = 1'b1; dmem_ack = 1'b1; step("t5_ack");
        idle(); step("t5_after");
        check_eq("t5_sticky", {31'd0, err_timeout}, 32'd1);

        // 6: reset in the middle of DISCARD
        do_reset("t6");
        idle(); ex_branch_taken = 1'b1; imem_ack = 1'b0; step("t6_br");
        idle(); imem_ack = 1'b0; step("t6_dis");
        do_reset("t6_mid");
        check_eq("t6_cnt_clear", stall_cnt, 32'd0);
        idle(); step("t6_run");

        // Random traffic
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            imem_ack        = ($urandom_range(0, 3) != 0);
            dmem_req        = ($urandom_range(0, 3) == 0);
            dmem_ack        = $urandom_range(0, 1);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_use_rs1      = $urandom_range(0, 1);
            id_use_rs2      = $urandom_range(0, 1);
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = $urandom_range(0, 1);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the RV32I 5-stage pipeline.
- Drives the stall and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs it arbitrates: instruction-fetch ACK latency, load-use hazards, taken-branch redirects and data-memory wait states.
- Also tracks wrong-path fetches in flight, and keeps a stall-cycle counter and a sticky data-memory timeout flag.

Parameters:
- WAIT_TIMEOUT, 64: max consecutive dmem wait cycles before err_timeout sets.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- imem_ack  in  1  instruction for the current fetch is valid
- dmem_req  in  1  MEM stage has a load/store outstanding
- dmem_ack  in  1  data memory completes the MEM-stage access
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- pc_stall  out  1  hold PC
- pc_redirect  out  1  PC loads the branch target
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  IF/ID captures a bubble (ACK_out=0)
- id_ex_stall  out  1  hold ID/EX
- id_ex_flush  out  1  ID/EX captures a bubble
- ex_mem_stall  out  1  hold EX/MEM
- mem_wb_flush  out  1  MEM/WB captures a bubble
- stall_cnt  out  CNT_W  cycles with pc_stall=1 (saturating)
- err_timeout  out  1  sticky: dmem wait exceeded WAIT_TIMEOUT

Behaviour:
- Reset (reset=0, async):
  - state=RUN; wait_cnt=0; stall_cnt=0; err_timeout=0.
  - if_id_flush=id_ex_flush=mem_wb_flush=1; all stalls and pc_redirect=0.
- Control outputs are combinational from state plus inputs. state, wait_cnt, stall_cnt and err_timeout are registered.
- Priority, highest first. Conditions evaluated in the same cycle:
  - P1 DMEM_WAIT: dmem_req & ~dmem_ack.
    - pc/if_id/id_ex/ex_mem stalls all =1; mem_wb_flush=1.
    - ex_branch_taken is ignored this cycle (branch is held in EX); no redirect.
  - P2 REDIRECT: ex_branch_taken.
    - pc_redirect=1; if_id_flush=1; id_ex_flush=1; no stalls.
    - If imem_ack=0 this cycle, next state=DISCARD.
  - P3 LOAD_USE: ex_mem_read & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
    - pc_stall=1; if_id_stall=1; id_ex_flush=1. Exactly one bubble; the hazard clears when the load leaves EX.
  - P4 FETCH_WAIT: imem_ack=0 in state RUN.
    - pc_stall=1; if_id_stall=1; id_ex_flush=1.
    - ID instruction is not re-issued; EX and later stages proceed.
  - Otherwise: all controls 0 (normal advance).
- States:
  - RUN: default.
  - DISCARD: a wrong-path fetch is outstanding.
    - pc_stall=1 (redirected PC held); if_id_flush=1.
    - On imem_ack=1, the returned instruction is dropped (if_id_flush=1 that cycle) and the next state is RUN.
    - P1 still overrides and freezes the pipeline. A further ex_branch_taken cannot occur, since EX holds a bubble.
- wait_cnt:
  - Increments each P1 cycle, saturating at WAIT_TIMEOUT; clears on any non-P1 cycle.
  - err_timeout sets when wait_cnt reaches WAIT_TIMEOUT; it clears only on reset.
- stall_cnt increments on every cycle with pc_stall=1 and saturates at all-ones.
- rd==x0 never creates a load-use hazard.
- Reset asserted mid-wait or mid-DISCARD returns immediately to RUN with the reset outputs; the pending fetch is not tracked.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - enum ctrl_state_t {RUN, DISCARD}.
  - Register-index width constant REG_AW=5.
  - Packed struct pipe_ctrl_t bundling the stall/flush outputs, reused by the stage registers.
- One natural sub-module: hazard_detect (combinational load-use compare).

Test Plan:
1. Load x5 in EX; ID instruction uses rs1=x5 with id_use_rs1=1 → exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1, then 0; stall_cnt=1. Repeat with ex_rd=0 → no stall.
2. imem_ack low for 3 cycles in RUN → pc_stall=if_id_stall=id_ex_flush=1 for exactly 3 cycles; stall_cnt=3.
3. ex_branch_taken=1 with imem_ack=0, then ack after 2 cycles → pc_redirect for 1 cycle; DISCARD for 2 cycles with if_id_flush=1 and pc_stall=1; the acked instruction is flushed; RUN resumes.
4. dmem_req=1, dmem_ack=0 for 4 cycles while ex_branch_taken=1 and a load-use is present → all four stalls plus mem_wb_flush for 4 cycles, no redirect. On the ack cycle, pc_redirect=1 and load-use is suppressed.
5. With WAIT_TIMEOUT=8, hold dmem_ack=0 for 10 cycles → err_timeout=1 after the 8th wait cycle and stays 1 after ack, until reset.
6. Assert reset low mid-DISCARD → outputs immediately reach reset values; after release, state=RUN and stall_cnt=0.
